stopwatch_ctrl: RTL

//  Control FSM for the two-digit seconds counter of the lab stopwatch.
//  - Turns three debounced push-button levels (start/stop, clear, lap) into the counter's init_regs and count_enabled.
//  - Freezes a lap value for the display while the counter keeps running.
//  - Sits between the button debouncers and the counter; display_reading feeds the 7-segment driver.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/stopwatch_btn_edge.sv | 20 ++
 rtl/stopwatch_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control block.
// The saturation option in stopwatch_ctrl is enabled with STOPWATCH_SATURATE_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam int unsigned TIME_W_DEF = 8;
  localparam logic [7:0]  SAT_VALUE_DEF = 8'h99;

endpackage

// File: rtl/stopwatch_btn_edge.sv
// Rising-edge detector for one debounced button level.
// History resets high so a button held through reset never reports a press.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic prev_q;

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= btn_i;
  end

  assign press_o = btn_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the two-digit BCD seconds counter, with lap freeze of the display.
// Define STOPWATCH_SATURATE_EN to stop counting when the reading reaches SAT_VALUE.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TIME_W = TIME_W_DEF
`ifdef STOPWATCH_SATURATE_EN
  ,
  parameter logic [TIME_W-1:0] SAT_VALUE = TIME_W'(SAT_VALUE_DEF)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start_stop,
  input  logic              btn_clear,
  input  logic              btn_lap,
  input  logic [TIME_W-1:0] time_reading,
  output logic              init_regs,
  output logic              count_enabled,
  output logic [TIME_W-1:0] display_reading,
  output logic              running,
  output logic              lap_active
);

  state_e              state_q, state_d;
  logic                lap_active_q, lap_active_d;
  logic [TIME_W-1:0]   lap_snapshot_q, lap_snapshot_d;
  logic                init_regs_q, count_enabled_q, running_q;
  logic                ss_press, clr_press, lap_press;
  logic                sat_hit;

  btn_edge u_edge_ss  (.clk(clk), .rst_n(rst_n), .btn_i(btn_start_stop), .press_o(ss_press));
  btn_edge u_edge_clr (.clk(clk), .rst_n(rst_n), .btn_i(btn_clear),      .press_o(clr_press));
  btn_edge u_edge_lap (.clk(clk), .rst_n(rst_n), .btn_i(btn_lap),        .press_o(lap_press));

`ifdef STOPWATCH_SATURATE_EN
  assign sat_hit = (time_reading == SAT_VALUE);
`else
  assign sat_hit = 1'b0;
`endif

  // Priority clear > start_stop (or saturation) > lap; lower presses in the same cycle are dropped.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    lap_active_d   = lap_active_q;
    lap_snapshot_d = lap_snapshot_q;
    case (state_q)
      IDLE: begin
        if (!clr_press && ss_press) state_d = RUN;
      end
      RUN: begin
        if (clr_press) begin
          state_d      = IDLE;
          lap_active_d = 1'b0;
        end else if (ss_press || sat_hit) begin
          state_d = PAUSE;
        end else if (lap_press) begin
          lap_active_d = ~lap_active_q;
          if (!lap_active_q) lap_snapshot_d = time_reading;
        end
      end
      PAUSE: begin
        if (clr_press) begin
          state_d      = IDLE;
          lap_active_d = 1'b0;
        end else if (ss_press) begin
          if (!sat_hit) state_d = RUN;
        end else if (lap_press && lap_active_q) begin
          lap_active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      lap_active_q    <= 1'b0;
      lap_snapshot_q  <= '0;
      init_regs_q     <= 1'b1;
      count_enabled_q <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      lap_active_q    <= lap_active_d;
      lap_snapshot_q  <= lap_snapshot_d;
      init_regs_q     <= (state_d == IDLE);
      count_enabled_q <= (state_d == RUN);
      running_q       <= (state_d == RUN);
    end
  end

  assign init_regs       = init_regs_q;
  assign count_enabled   = count_enabled_q;
  assign running         = running_q;
  assign lap_active      = lap_active_q;
  assign display_reading = lap_active_q ? lap_snapshot_q : time_reading;

endmodule
